sub_16bit_pipe: RTL and testbench



---
 rtl/sub_16bit_pipe.sv | 132 +++++++++++++
 tb/tb_sub_16bit_pipe.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/sub_16bit_pipe.sv
`timescale 1ns/1ps
// sub_16bit_pipe: pipelined two's-complement subtractor, Diff = A + ~B + 1,
// one 4-bit slice per stage with a registered inter-slice carry.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   i_a, i_b         minuend / subtrahend
//   i_in_valid       operands present this cycle
//   o_in_ready       operands accepted this cycle (combinational)
//   o_diff           A - B modulo 2^WIDTH
//   o_bout           unsigned borrow (A < B)
//   o_v              signed overflow
//   o_z              difference is zero
//   o_out_valid      result and flags valid
//   i_out_ready      consumer takes the result this cycle
module sub_16bit_pipe #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    output logic [WIDTH-1:0] o_diff,
    output logic             o_bout,
    output logic             o_v,
    output logic             o_z,
    output logic             o_out_valid,
    input  logic             i_out_ready
);

    // WIDTH must be a multiple of 4 and at least 8 (two or more slices).
    localparam int unsigned NW   = 4;
    localparam int unsigned NSTG = WIDTH / NW;

    // Per-stage state. Operand registers hold only the bits not yet consumed,
    // shifted down so the next slice always finds its nibble in [3:0].
    logic [NSTG-1:0]            r_vld;
    logic [NSTG-1:0][WIDTH-1:0] r_d;
    logic [NSTG-2:0]            r_c;
    logic [NSTG-2:0][WIDTH-1:0] r_a;
    logic [NSTG-2:0][WIDTH-1:0] r_nb;
    logic [NSTG-2:0]            r_sa;
    logic [NSTG-2:0]            r_sb;
    logic                       r_bout;
    logic                       r_v;
    logic                       r_z;

    logic                       w_en;
    logic [NSTG-1:0][WIDTH-1:0] w_d;
    logic [NSTG-1:0]            w_c;
    logic                       w_unused;

    // 4-bit carry-lookahead slice; returns {carry_out, sum}.
    function automatic logic [NW:0] cla4(input logic [NW-1:0] a,
                                         input logic [NW-1:0] nb,
                                         input logic          cin);
        logic [NW-1:0] g;
        logic [NW-1:0] p;
        logic [NW:0]   c;
        g    = a & nb;
        p    = a | nb;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & cin);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);
        return {c[4], a ^ nb ^ c[NW-1:0]};
    endfunction

    // Global advance: the whole pipe moves unless a result is waiting unread.
    assign w_en       = ~r_vld[NSTG-1] | i_out_ready;
    assign o_in_ready = w_en;

    // Next contents of every stage: predecessor's partial diff plus one nibble.
    always_comb begin
        w_d = '0;
        w_c = '0;
        {w_c[0], w_d[0][NW-1:0]} = cla4(i_a[NW-1:0], ~i_b[NW-1:0], 1'b1);
        for (int unsigned k = 1; k < NSTG; k++) begin
            w_d[k] = r_d[k-1];
            {w_c[k], w_d[k][NW*k +: NW]} = cla4(r_a[k-1][NW-1:0],
                                                r_nb[k-1][NW-1:0], r_c[k-1]);
        end
    end

    // Pipeline registers; flags are formed alongside the final slice.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld  <= '0;
            r_d    <= '0;
            r_c    <= '0;
            r_a    <= '0;
            r_nb   <= '0;
            r_sa   <= '0;
            r_sb   <= '0;
            r_bout <= 1'b0;
            r_v    <= 1'b0;
            r_z    <= 1'b0;
        end else if (w_en) begin
            r_vld   <= {r_vld[NSTG-2:0], i_in_valid};
            r_d     <= w_d;
            r_c     <= w_c[NSTG-2:0];
            r_a[0]  <= i_a >> NW;
            r_nb[0] <= (~i_b) >> NW;
            r_sa[0] <= i_a[WIDTH-1];
            r_sb[0] <= i_b[WIDTH-1];
            for (int unsigned k = 1; k < NSTG - 1; k++) begin
                r_a[k]  <= r_a[k-1] >> NW;
                r_nb[k] <= r_nb[k-1] >> NW;
                r_sa[k] <= r_sa[k-1];
                r_sb[k] <= r_sb[k-1];
            end
            r_bout <= ~w_c[NSTG-1];
            r_v    <= (r_sa[NSTG-2] ^ r_sb[NSTG-2])
                    & (w_d[NSTG-1][WIDTH-1] ^ r_sa[NSTG-2]);
            r_z    <= (w_d[NSTG-1] == '0);
        end
    end

    // The last operand stage only ever supplies its low nibble.
    assign w_unused = ^{r_a[NSTG-2][WIDTH-1:NW], r_nb[NSTG-2][WIDTH-1:NW]};

    assign o_diff      = r_d[NSTG-1];
    assign o_bout      = r_bout;
    assign o_v         = r_v;
    assign o_z         = r_z;
    assign o_out_valid = r_vld[NSTG-1];

endmodule

// File: tb/tb_sub_16bit_pipe.sv
`timescale 1ns/1ps
// tb_sub_16bit_pipe: directed and random checks of the pipelined subtractor
// against an arithmetic reference, with a FIFO of accepted operations.
module tb_sub_16bit_pipe;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
    } op_t;

    typedef struct packed {
        logic [15:0] diff;
        logic        bout;
        logic        v;
        logic        z;
    } res_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] ta;
    logic [15:0] tb;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] diff;
    logic        bout;
    logic        v;
    logic        z;
    logic        out_valid;
    logic        out_ready;

    op_t  q[$];
    int   n_chk    = 0;
    int   n_err    = 0;
    int   n_taken  = 0;
    logic last_acc = 1'b0;

    sub_16bit_pipe #(.WIDTH(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_a        (ta),
        .i_b        (tb),
        .i_in_valid (in_valid),
        .o_in_ready (in_ready),
        .o_diff     (diff),
        .o_bout     (bout),
        .o_v        (v),
        .o_z        (z),
        .o_out_valid(out_valid),
        .i_out_ready(out_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference: plain integer arithmetic, overflow from the exact signed result.
    function automatic res_t model(input logic [15:0] a, input logic [15:0] b);
        res_t r;
        int   sd;
        r.diff = a - b;
        r.bout = (a < b);
        sd     = int'($signed(a)) - int'($signed(b));
        r.v    = (sd > 32767) || (sd < -32768);
        r.z    = (r.diff == 16'h0000);
        return r;
    endfunction

    // One clock: inputs already driven at negedge; score accepts/takes, advance.
    task automatic cycle();
        logic take;
        op_t  op;
        res_t m;
        #1;
        last_acc = in_valid & in_ready & ~rst;
        take     = out_valid & out_ready & ~rst;
        if (take) begin
            chk("unexpected_out", 32'(q.size() > 0), 32'd1);
            if (q.size() > 0) begin
                op = q.pop_front();
                m  = model(op.a, op.b);
                chk("diff", 32'(diff), 32'(m.diff));
                chk("bout", 32'(bout), 32'(m.bout));
                chk("v",    32'(v),    32'(m.v));
                chk("z",    32'(z),    32'(m.z));
                n_taken++;
            end
        end
        if (last_acc) q.push_back({ta, tb});
        @(posedge clk);
        if (rst) q.delete();
        @(negedge clk);
    endtask

    task automatic issue(input logic [15:0] a, input logic [15:0] b);
        bit done = 0;
        ta = a; tb = b; in_valid = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            cycle();
            done = last_acc;
        end
        chk("issue_accept", 32'(done), 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 50 && q.size() > 0; i++) cycle();
        chk("drain_empty", 32'(q.size()), 32'd0);
    endtask

    // Single op: out_valid must appear exactly in the 4th cycle after accept, for one cycle.
    task automatic lat_check(input logic [15:0] a, input logic [15:0] b);
        ta = a; tb = b; in_valid = 1'b1; out_ready = 1'b1;
        cycle();
        chk("lat_accept", 32'(last_acc), 32'd1);
        in_valid = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            #1 chk("lat_early", 32'(out_valid), 32'd0);
            cycle();
        end
        #1 chk("lat_at4", 32'(out_valid), 32'd1);
        cycle();
        #1 chk("lat_one_cycle", 32'(out_valid), 32'd0);
    endtask

    task automatic chk_reset_state();
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_diff",      32'(diff),      32'd0);
        chk("rst_bout",      32'(bout),      32'd0);
        chk("rst_v",         32'(v),         32'd0);
        chk("rst_z",         32'(z),         32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
    endtask

    initial begin
        int          i;
        int          base;
        int          stall_cnt;
        logic [15:0] hold;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; ta = '0; tb = '0;
        @(negedge clk);
        cycle();
        cycle();
        rst = 1'b0;
        chk_reset_state();

        // Basic subtract with exact latency.
        lat_check(16'h1234, 16'h0234);

        // Borrow chains, overflow, zero.
        issue(16'h1000, 16'h0001);
        issue(16'h0000, 16'h0001);
        issue(16'h8000, 16'h0001);
        issue(16'h7FFF, 16'hFFFF);
        issue(16'h5555, 16'h5555);
        drain();

        // Back-to-back with a 3-cycle stall after the 2nd result.
        base = n_taken; i = 1; stall_cnt = 0; hold = '0;
        for (int c = 0; c < 100 && (i <= 8 || q.size() > 0); c++) begin
            ta = 16'(i * 256); tb = 16'(i);
            in_valid = (i <= 8);
            if (n_taken - base == 2 && stall_cnt < 3) begin
                out_ready = 1'b0;
                stall_cnt++;
            end else begin
                out_ready = 1'b1;
            end
            if (!out_ready) begin
                #1;
                chk("stall_out_valid", 32'(out_valid), 32'd1);
                chk("stall_in_ready",  32'(in_ready),  32'd0);
                if (stall_cnt == 1) hold = diff;
                else chk("stall_diff_stable", 32'(diff), 32'(hold));
            end
            cycle();
            if (last_acc) i++;
        end
        chk("bp_count", 32'(n_taken - base), 32'd8);
        chk("bp_stall_len", 32'(stall_cnt), 32'd3);
        drain();

        // Reset with three operations in flight; operands during reset are ignored.
        issue(16'h1111, 16'h0001);
        issue(16'h2222, 16'h0002);
        issue(16'h3333, 16'h0003);
        rst = 1'b1; in_valid = 1'b1; ta = 16'hDEAD; tb = 16'hBEEF;
        cycle();
        rst = 1'b0; in_valid = 1'b0;
        chk_reset_state();
        lat_check(16'h0003, 16'h0005);
        chk("post_rst_taken_empty", 32'(q.size()), 32'd0);

        // Random traffic with random back-pressure.
        for (int c = 0; c < 10000; c++) begin
            ta        = 16'($urandom);
            tb        = 16'($urandom);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
